// File: rtl/dcache_pkg.sv
// dcache_pkg: shared definitions for the data-cache controller slice.
//   - default address/index/offset widths
//   - state encoding (codes are visible on the cs output and RHIT=9 is also
//     decoded by the replacement logic, so the values are fixed)
package dcache_pkg;

   localparam int unsigned ADDR_W_DEF  = 32;
   localparam int unsigned INDEX_W_DEF = 9;
   localparam int unsigned OFFS_W_DEF  = 4;

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      LOOKUP = 4'd1,
      MEM_RD = 4'd2,
      MEM_WR = 4'd3,
      FILL   = 4'd4,
      DONE   = 4'd7,
      RHIT   = 4'd9
   } state_t;

endpackage

// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: CPU, tag-array, cache-array and memory signals of the
// data-cache controller.
//   slave  modport: controller view (cpu_*/tag/mem_ack in, strobes out)
//   master modport: environment view (CPU, tag array, memory)
interface dcache_ctrl_if
   import dcache_pkg::*;
#(
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned INDEX_W = INDEX_W_DEF
) ();

   logic               cpu_req;
   logic               cpu_we;
   logic [ADDR_W-1:0]  cpu_addr;
   logic               cpu_ready;
   logic               valid0;
   logic               valid1;
   logic               match0;
   logic               match1;
   logic               way_sel;
   logic [INDEX_W-1:0] index;
   logic               cache_wr;
   logic               fill_way;
   logic               mem_req;
   logic               mem_we;
   logic [ADDR_W-1:0]  mem_addr;
   logic               mem_ack;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, valid0, valid1, match0, match1,
             way_sel, mem_ack,
      output cpu_ready, index, cache_wr, fill_way, mem_req, mem_we, mem_addr
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, valid0, valid1, match0, match1,
             way_sel, mem_ack,
      input  cpu_ready, index, cache_wr, fill_way, mem_req, mem_we, mem_addr
   );

endinterface

// File: rtl/sat_cnt16.sv
// sat_cnt16: 16-bit up counter with enable that saturates at 16'hFFFF.
//   clk : rising-edge clock
//   rst : asynchronous active-high clear
//   en  : increment request
//   cnt : current count
module sat_cnt16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [15:0] cnt
);

   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en && (cnt_q != '1)) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: two-way data-cache controller FSM, write-through and
// no-write-allocate.
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : dcache_ctrl_if.slave (CPU request, tag compare, cache write
//               strobe, memory request/ack)
//   cs        : current state code
//   hit_cnt   : saturating read-hit count
//   miss_cnt  : saturating read-miss count
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned INDEX_W = INDEX_W_DEF,
   parameter int unsigned OFFS_W  = OFFS_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   dcache_ctrl_if.slave        bus,
   output logic [3:0]          cs,
   output logic [15:0]         hit_cnt,
   output logic [15:0]         miss_cnt
);

   state_t             state_q, state_d;
   logic               we_q, we_d;
   logic               hit_q, hit_d;
   logic               hit_way_q, hit_way_d;
   logic               fill_way_q, fill_way_d;
   logic [INDEX_W-1:0] index_q, index_d;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
   logic               cache_wr_q, cache_wr_d;
   logic               mem_req_q, mem_req_d;
   logic               mem_we_q, mem_we_d;
   logic               cpu_ready_q, cpu_ready_d;
   logic               hit0, hit1;
   logic               hit_inc, miss_inc;

   assign hit0 = bus.valid0 & bus.match0;
   assign hit1 = bus.valid1 & bus.match1;

   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      hit_d      = hit_q;
      hit_way_d  = hit_way_q;
      fill_way_d = fill_way_q;
      index_d    = index_q;
      mem_addr_d = mem_addr_q;
      hit_inc    = 1'b0;
      miss_inc   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.cpu_req) begin
               we_d    = bus.cpu_we;
               index_d = bus.cpu_addr[INDEX_W+OFFS_W-1:OFFS_W];
               // reads fetch a whole line, writes go through at byte address
               mem_addr_d = bus.cpu_we ? bus.cpu_addr
                          : {bus.cpu_addr[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            // tag result is captured here so MEM_WR can use it at ack time
            hit_d     = hit0 | hit1;
            hit_way_d = ~hit0;
            if (we_q)             state_d = MEM_WR;
            else if (hit0 | hit1) state_d = RHIT;
            else                  state_d = MEM_RD;
         end
         RHIT: begin
            hit_inc = 1'b1;
            state_d = DONE;
         end
         MEM_RD: begin
            if (bus.mem_ack) begin
               miss_inc   = 1'b1;
               fill_way_d = bus.way_sel;
               state_d    = FILL;
            end
         end
         MEM_WR: begin
            if (bus.mem_ack) begin
               if (hit_q) begin
                  fill_way_d = hit_way_q;
                  state_d    = FILL;
               end else begin
                  state_d = DONE;
               end
            end
         end
         FILL:    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // strobes are registered from the next state so they align with it
      cache_wr_d  = (state_d == FILL);
      mem_req_d   = (state_d == MEM_RD) || (state_d == MEM_WR);
      mem_we_d    = (state_d == MEM_WR);
      cpu_ready_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         hit_q       <= 1'b0;
         hit_way_q   <= 1'b0;
         fill_way_q  <= 1'b0;
         index_q     <= '0;
         mem_addr_q  <= '0;
         cache_wr_q  <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         cpu_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         hit_q       <= hit_d;
         hit_way_q   <= hit_way_d;
         fill_way_q  <= fill_way_d;
         index_q     <= index_d;
         mem_addr_q  <= mem_addr_d;
         cache_wr_q  <= cache_wr_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         cpu_ready_q <= cpu_ready_d;
      end
   end

   sat_cnt16 u_hit_cnt (
      .clk (clk),
      .rst (rst),
      .en  (hit_inc),
      .cnt (hit_cnt)
   );

   sat_cnt16 u_miss_cnt (
      .clk (clk),
      .rst (rst),
      .en  (miss_inc),
      .cnt (miss_cnt)
   );

   assign cs            = state_q;
   assign bus.cpu_ready = cpu_ready_q;
   assign bus.index     = index_q;
   assign bus.cache_wr  = cache_wr_q;
   assign bus.fill_way  = fill_way_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, CPU/memory byte-address width.
REQ-002 Parameter INDEX_W, default 9, set-index width (512 sets); index = cpu_addr[INDEX_W+OFFS_W-1:OFFS_W].
REQ-003 Parameter OFFS_W, default 4, line-offset width.
REQ-004 clk  in  1  rising-edge system clock.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 cpu_req  in  1  CPU access request; sampled only in IDLE.
REQ-007 cpu_we  in  1  1 = write, 0 = read; latched with cpu_req.
REQ-008 cpu_addr  in  ADDR_W  access address; latched with cpu_req.
REQ-009 cpu_ready  out  1  one-cycle completion pulse.
REQ-010 valid0, valid1, match0, match1  in  1 each  tag-array valid/tag-compare per way for the presented index; meaningful from LOOKUP onward.
REQ-011 way_sel  in  1  victim way from the replacement logic.
REQ-012 index  out  INDEX_W  latched set index, stable from LOOKUP through DONE.
REQ-013 cache_wr  out  1  one-cycle cache-array write strobe (also replacement-update trigger).
REQ-014 fill_way  out  1  way written when cache_wr=1.
REQ-015 cs  out  4  current state code.
REQ-016 mem_req, mem_we  out  1 each  memory request and direction.
REQ-017 mem_addr  out  ADDR_W  latched address, offset bits forced to 0 on reads.
REQ-018 mem_ack  in  1  memory completion, single-cycle pulse.
REQ-019 hit_cnt, miss_cnt  out  16 each  read-hit / read-miss statistics.

Function
REQ-020 States and codes: IDLE=0, LOOKUP=1, MEM_RD=2, MEM_WR=3, FILL=4, DONE=7, RHIT=9; all other codes unreachable, decode to IDLE.
REQ-021 IDLE: cpu_req=1 latches cpu_we/cpu_addr, next LOOKUP; otherwise stay.
REQ-022 LOOKUP: hit0=valid0&match0, hit1=valid1&match1, hit=hit0|hit1; hit_way=hit0?0:1 (both hit -> way0).
REQ-023 LOOKUP read: hit -> RHIT, miss -> MEM_RD; write -> MEM_WR regardless of hit.
REQ-024 RHIT: one cycle, hit_cnt increments, next DONE; read-hit latency = 3 cycles from cpu_req sample to cpu_ready.
REQ-025 MEM_RD: mem_req=1, mem_we=0 held until mem_ack=1, then miss_cnt increments, next FILL with fill_way=way_sel.
REQ-026 MEM_WR: mem_req=1, mem_we=1 held until mem_ack; then hit -> FILL with fill_way=hit_way, miss -> DONE (write-through, no-write-allocate).
REQ-027 FILL: cache_wr=1 for exactly one cycle, next DONE.
REQ-028 DONE: cpu_ready=1 for exactly one cycle, next IDLE; a new cpu_req accepted earliest the cycle after DONE.
REQ-029 cpu_req outside IDLE and mem_ack outside MEM_RD/MEM_WR ignored.
REQ-030 fill_way/way_sel registered on entry to FILL; held stable through FILL.
REQ-031 Counters saturate at 16'hFFFF; no wrap.
REQ-032 cache_wr, mem_req, cpu_ready registered outputs, glitch-free.

Reset
REQ-033 rst=1 forces state IDLE, cs=0, cpu_ready=0, cache_wr=0, mem_req=0, mem_we=0, fill_way=0, index=0, mem_addr=0, hit_cnt=0, miss_cnt=0.
REQ-034 Reset mid-transaction abandons it: mem_req drops immediately, no cpu_ready, no cache_wr.

Structure
REQ-035 Package dcache_pkg holds state codes (including RHIT=9 shared with the replacement logic), ADDR_W/INDEX_W/OFFS_W defaults.
REQ-036 One sub-module sat_cnt16 (enable, saturating 16-bit) instantiated twice; FSM in dcache_ctrl.

Verification
REQ-037 Read hit: valid0=1, match0=1, read addr 0x0000_0120 -> cs 0,1,9,7,0; cpu_ready on cycle 3; hit_cnt=1; no mem_req, no cache_wr.
REQ-038 Read miss: valid0=valid1=0, way_sel=1, mem_ack after 5 cycles -> mem_addr=addr&~0xF, cache_wr one cycle with fill_way=1, miss_cnt=1, cpu_ready once.
REQ-039 Write hit way1 (valid1=match1=1): mem_we=1 until ack -> FILL fill_way=1; write miss -> no cache_wr, cpu_ready after ack.
REQ-040 rst asserted in MEM_RD -> mem_req=0 same cycle, cs=0, later stray mem_ack ignored.
REQ-041 65536 read hits -> hit_cnt=0xFFFF, stays 0xFFFF after another hit.
REQ-042 cpu_req held high continuously -> back-to-back transactions, each cpu_ready exactly one cycle, IDLE visited between.
